// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types, constants and helpers for the segment scan controller
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// rtl/seg_scan_prescaler.sv - per-digit slot counter with terminal-count tick
module seg_scan_prescaler #(
    parameter  int CLK_DIV = 50000,
    localparam int CNT_W   = $clog2(CLK_DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_tick
);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick = (r_cnt == CNT_W'(CLK_DIV - 1));

    // Count lit cycles within a slot; wrap at terminal count, clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller driving one shared decoder
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] din,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          blank_lz,
    output logic [DIGIT_W-1:0]            bcd,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_done,
    output logic                          pending
);

    localparam int IDX_W = $clog2(NUM_DIGITS);

    state_t                        r_state;
    state_t                        w_state_next;
    logic [IDX_W-1:0]              r_idx;
    logic [IDX_W-1:0]              w_idx_next;
    logic                          w_tick;

    logic [DIGIT_W*NUM_DIGITS-1:0] r_disp;
    logic [NUM_DIGITS-1:0]         r_dpreg;
    logic [DIGIT_W*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]         r_shadow_dp;
    logic                          r_pending;
    logic [DIGIT_W*NUM_DIGITS-1:0] w_disp_next;
    logic [NUM_DIGITS-1:0]         w_dpreg_next;
    logic                          w_boundary;
    logic                          w_xfer;

    logic [NUM_DIGITS-1:0]         w_lz;
    logic                          w_digit_blank;
    logic [NUM_DIGITS-1:0]         w_an_next;
    logic [DIGIT_W-1:0]            w_bcd_next;
    logic                          w_dp_next;
    logic                          w_fd_next;

    logic [NUM_DIGITS-1:0]         r_an;
    logic [DIGIT_W-1:0]            r_bcd;
    logic                          r_dp;
    logic                          r_frame_done;

    // Counter only advances while a digit is lit; dropping en restarts the slot
    seg_scan_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_inc  (r_state == SHOW),
        .i_clr  (!en),
        .o_tick (w_tick)
    );

    // Scan state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Next-state: lit slot, one blank gap, advance digit; en low aborts to IDLE
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            IDLE: begin
                w_idx_next = '0;
                if (en) w_state_next = SHOW;
            end
            SHOW: begin
                if (w_tick) w_state_next = BLANK;
            end
            BLANK: begin
                w_state_next = SHOW;
                w_idx_next   = (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
            end
            default: begin
                w_state_next = IDLE;
                w_idx_next   = '0;
            end
        endcase
        if (!en) begin
            w_state_next = IDLE;
            w_idx_next   = '0;
        end
    end

    // Shadow moves to the display only at a frame boundary or while idle,
    // so a frame never shows a mix of old and new digits
    assign w_boundary   = (r_state == BLANK) && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_xfer       = r_pending && (w_boundary || (r_state == IDLE));
    assign w_disp_next  = w_xfer ? r_shadow    : r_disp;
    assign w_dpreg_next = w_xfer ? r_shadow_dp : r_dpreg;

    // Double buffer update; a load in the boundary cycle stays pending for the next frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp      <= '0;
            r_dpreg     <= '0;
            r_shadow    <= '0;
            r_shadow_dp <= '0;
            r_pending   <= 1'b0;
        end else begin
            r_disp  <= w_disp_next;
            r_dpreg <= w_dpreg_next;
            if (load) begin
                r_shadow    <= din;
                r_shadow_dp <= dp_in;
                r_pending   <= 1'b1;
            end else if (w_xfer) begin
                r_pending   <= 1'b0;
            end
        end
    end

    // w_lz[k] is set when digit k and every higher digit is zero with no decimal point
    always_comb begin
        logic v_acc;
        w_lz  = '0;
        v_acc = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_acc   = v_acc && (w_disp_next[k*DIGIT_W +: DIGIT_W] == '0) && !w_dpreg_next[k];
            w_lz[k] = v_acc;
        end
    end

    // Output values for the upcoming cycle, derived from next state so outputs can be registered
    always_comb begin
        w_digit_blank = blank_lz && (w_idx_next != '0) && w_lz[w_idx_next];
        w_an_next     = '0;
        w_bcd_next    = r_bcd;
        w_dp_next     = r_dp;
        if (w_state_next == SHOW) begin
            w_bcd_next = w_disp_next[w_idx_next*DIGIT_W +: DIGIT_W];
            w_dp_next  = w_dpreg_next[w_idx_next];
            if (!w_digit_blank) begin
                w_an_next = NUM_DIGITS'(onehot(3'(w_idx_next)));
            end
        end
        w_fd_next = (w_state_next == BLANK) && (w_idx_next == IDX_W'(NUM_DIGITS - 1));
    end

    // Registered decoder and digit-enable outputs; reset darkens the display immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= '0;
            r_bcd        <= '0;
            r_dp         <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_next;
            r_bcd        <= w_bcd_next;
            r_dp         <= w_dp_next;
            r_frame_done <= w_fd_next;
        end
    end

    assign an         = r_an;
    assign bcd        = r_bcd;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bcd;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;
    logic [9:0]  w_got;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS (4),
        .CLK_DIV    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .din        (din),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .bcd        (bcd),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    assign w_got = {an, bcd, dp, frame_done};

    // Expected {an,bcd,dp,frame_done} for cycle c of a 20-cycle frame (slot = 4 lit + 1 gap)
    function automatic logic [9:0] f_exp(input int c, input logic [15:0] d,
                                         input logic [3:0] dps, input logic [3:0] dark);
        int         s;
        int         p;
        logic [3:0] a;
        s = c / 5;
        p = c % 5;
        a = (p < 4 && !dark[s]) ? (4'b0001 << s) : 4'b0000;
        f_exp = {a, d[s*4 +: 4], dps[s], (c == 19)};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (w_got !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", w_got, 10'd0);
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_pending got=%b exp=0", pending);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (w_got !== 10'd0) begin
            errors++;
            $display("FAIL idle_outputs got=%h exp=%h", w_got, 10'd0);
        end
    endtask

    task automatic test_basic();
        load = 1'b1; din = 16'h1234; dp_in = 4'b0100;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL idle_load_pending got=%b exp=1", pending);
        end
        en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (w_got !== f_exp(c, 16'h1234, 4'b0100, 4'b0000)) begin
                errors++;
                $display("FAIL basic_frame c=%0d got=%h exp=%h", c, w_got, f_exp(c, 16'h1234, 4'b0100, 4'b0000));
            end
            if (c == 0) begin
                checks++;
                if (pending !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_xfer_pending got=%b exp=0", pending);
                end
            end
        end
    endtask

    task automatic test_tearing();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (w_got !== f_exp(c, 16'h1234, 4'b0100, 4'b0000)) begin
                errors++;
                $display("FAIL tear_old_frame c=%0d got=%h exp=%h", c, w_got, f_exp(c, 16'h1234, 4'b0100, 4'b0000));
            end
            if (c >= 8) begin
                checks++;
                if (pending !== 1'b1) begin
                    errors++;
                    $display("FAIL tear_pending c=%0d got=%b exp=1", c, pending);
                end
            end
            if (c == 7) begin load = 1'b1; din = 16'h5678; dp_in = 4'b0000; end
            if (c == 8) load = 1'b0;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (w_got !== f_exp(c, 16'h5678, 4'b0000, 4'b0000)) begin
                errors++;
                $display("FAIL tear_new_frame c=%0d got=%h exp=%h", c, w_got, f_exp(c, 16'h5678, 4'b0000, 4'b0000));
            end
            if (c == 0) begin
                checks++;
                if (pending !== 1'b0) begin
                    errors++;
                    $display("FAIL tear_pending_clear got=%b exp=0", pending);
                end
            end
        end
    endtask

    task automatic test_collision();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (w_got !== f_exp(c, 16'h5678, 4'b0000, 4'b0000)) begin
                errors++;
                $display("FAIL coll_frame4 c=%0d got=%h exp=%h", c, w_got, f_exp(c, 16'h5678, 4'b0000, 4'b0000));
            end
            if (c == 5)  begin load = 1'b1; din = 16'h4321; end
            if (c == 6)  load = 1'b0;
            if (c == 19) begin load = 1'b1; din = 16'h9999; end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) load = 1'b0;
            checks++;
            if (w_got !== f_exp(c, 16'h4321, 4'b0000, 4'b0000)) begin
                errors++;
                $display("FAIL coll_old_shadow c=%0d got=%h exp=%h", c, w_got, f_exp(c, 16'h4321, 4'b0000, 4'b0000));
            end
            if (c == 0 || c == 19) begin
                checks++;
                if (pending !== 1'b1) begin
                    errors++;
                    $display("FAIL coll_pending c=%0d got=%b exp=1", c, pending);
                end
            end
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (w_got !== f_exp(c, 16'h9999, 4'b0000, 4'b0000)) begin
                errors++;
                $display("FAIL coll_late_frame c=%0d got=%h exp=%h", c, w_got, f_exp(c, 16'h9999, 4'b0000, 4'b0000));
            end
            if (c == 0) begin
                checks++;
                if (pending !== 1'b0) begin
                    errors++;
                    $display("FAIL coll_pending_clear got=%b exp=0", pending);
                end
            end
        end
    endtask

    task automatic test_blank_lz();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (w_got !== f_exp(c, 16'h9999, 4'b0000, 4'b0000)) begin
                errors++;
                $display("FAIL lz_prev_frame c=%0d got=%h exp=%h", c, w_got, f_exp(c, 16'h9999, 4'b0000, 4'b0000));
            end
            if (c == 0) blank_lz = 1'b1;
            if (c == 3) begin load = 1'b1; din = 16'h0070; dp_in = 4'b0000; end
            if (c == 4) load = 1'b0;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (w_got !== f_exp(c, 16'h0070, 4'b0000, 4'b1100)) begin
                errors++;
                $display("FAIL lz_frame c=%0d got=%h exp=%h", c, w_got, f_exp(c, 16'h0070, 4'b0000, 4'b1100));
            end
            if (c == 19) blank_lz = 1'b0;
        end
    endtask

    task automatic test_en_drop();
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (w_got !== f_exp(c, 16'h0070, 4'b0000, 4'b0000)) begin
                errors++;
                $display("FAIL drop_pre c=%0d got=%h exp=%h", c, w_got, f_exp(c, 16'h0070, 4'b0000, 4'b0000));
            end
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({an, frame_done} !== 5'd0) begin
                errors++;
                $display("FAIL drop_dark i=%0d got=%h exp=0", i, {an, frame_done});
            end
        end
        en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (w_got !== f_exp(c, 16'h0070, 4'b0000, 4'b0000)) begin
                errors++;
                $display("FAIL drop_restart c=%0d got=%h exp=%h", c, w_got, f_exp(c, 16'h0070, 4'b0000, 4'b0000));
            end
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (w_got !== f_exp(c, 16'h0070, 4'b0000, 4'b0000)) begin
                errors++;
                $display("FAIL arst_pre c=%0d got=%h exp=%h", c, w_got, f_exp(c, 16'h0070, 4'b0000, 4'b0000));
            end
            if (c == 3) begin load = 1'b1; din = 16'h1111; end
            if (c == 4) load = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (w_got !== 10'd0) begin
            errors++;
            $display("FAIL arst_dark got=%h exp=%h", w_got, 10'd0);
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++;
            $display("FAIL arst_pending got=%b exp=0", pending);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (w_got !== f_exp(c, 16'h0000, 4'b0000, 4'b0000)) begin
                errors++;
                $display("FAIL arst_after c=%0d got=%h exp=%h", c, w_got, f_exp(c, 16'h0000, 4'b0000, 4'b0000));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tearing();
        test_collision();
        test_blank_lz();
        test_en_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one BCD-to-7-segment decoder (inputs A,B,C,D plus dp) across NUM_DIGITS common-anode/cathode digits.
- Holds a double-buffered display register and steps through digits on a prescaled tick.
- Drives the shared decoder's BCD and dp inputs plus one-hot digit enables.
- Inserts a one-cycle blanking gap between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- CLK_DIV, 50000: clock cycles each digit is lit per slot (≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high; one clock domain only
- en  in  1  scan enable; 0 forces all digits off
- load  in  1  single-cycle strobe: capture din/dp_in into shadow buffer
- din  in  4*NUM_DIGITS  BCD nibbles; nibble k = digit k, digit 0 = least significant
- dp_in  in  NUM_DIGITS  decimal-point request per digit
- blank_lz  in  1  leading-zero blanking enable
- bcd  out  4  to shared decoder {A,B,C,D}, A = MSB
- dp  out  1  to shared decoder dp input
- an  out  NUM_DIGITS  digit enables, active-high one-hot, all-zero = dark
- frame_done  out  1  one-cycle pulse when the last digit's slot ends
- pending  out  1  shadow buffer holds data not yet displayed

Behaviour:
- All outputs are registered. Reset (async assert, sync to clk on release) sets:
  - an=0, bcd=0, dp=0, frame_done=0, pending=0
  - display reg = 0, shadow = 0, idx = 0, cnt = 0, state = IDLE
- States:
  - IDLE: an=0, idx=0, cnt=0. When en=1 → SHOW on the next cycle.
  - SHOW:
    - an=onehot(idx), unless the digit is blanked. bcd=disp[idx], dp=dp_reg[idx].
    - cnt increments each cycle. When cnt==CLK_DIV-1: cnt←0 and → BLANK.
  - BLANK: lasts one cycle. an=0; bcd and dp hold their values. Then idx←(idx+1) mod NUM_DIGITS and → SHOW.
- Frame timing:
  - Slot length is CLK_DIV+1 cycles. Frame length is NUM_DIGITS*(CLK_DIV+1) cycles.
  - First an assertion occurs 1 cycle after en rises while in IDLE.
- Frame boundary = the BLANK cycle with idx==NUM_DIGITS-1. In that cycle:
  - frame_done=1 for that cycle.
  - If pending: display reg←shadow, then pending←0.
- Load:
  - load=1 copies din/dp_in into shadow and sets pending←1. Accepted in any state, including IDLE.
  - A repeated load before the boundary overwrites the shadow; last write wins.
  - If load and the frame boundary fall in the same cycle, the boundary transfers the old shadow, and the new data is captured with pending left at 1. It displays at the next boundary.
  - In IDLE with pending=1, display reg←shadow immediately on the next cycle, so the first frame shows fresh data.
- Leading-zero blanking: when blank_lz=1, digit k>0 is suppressed (an bit stays 0, slot timing unchanged) if disp[k]==0, all higher digits are 0, and dp_reg for k and all higher digits is 0. Digit 0 is never blanked.
- Nibbles 10..15 pass through unchanged; the decoder defines their glyphs.
- en falling in any state → IDLE on the next edge: an=0, idx=0, cnt=0, frame_done not pulsed. The display reg, shadow and pending are retained.
- Reset mid-scan: immediate dark (an=0 asynchronously); all buffers are cleared.

Decomposition:
- Package seg_pkg holds:
  - state encoding (IDLE=2'd0, SHOW=2'd1, BLANK=2'd2)
  - DIGIT_W=4
  - function onehot(idx)
- Sub-module seg_scan_prescaler contains the cnt counter with sync clear and terminal-count output tick. The FSM, buffers and blanking logic stay in the top module.

Test Plan (NUM_DIGITS=4, CLK_DIV=4, slot=5, frame=20 cycles):
- Reset, en=1, load din=16'h1234, dp_in=4'b0100:
  - digit 0 shows bcd=4 with an=0001 for 4 cycles, then an=0000 for 1 cycle.
  - Then bcd=3/an=0010, bcd=2/an=0100 with dp=1, bcd=1/an=1000.
  - frame_done pulses at cycle 20 of the scan.
- Tearing: mid-frame load 16'h5678 → the current frame finishes showing 1234, pending=1 until the boundary, and the next frame shows 5678.
- Boundary collision: load 16'h9999 in the exact frame_done cycle → the next frame shows the previous shadow, pending stays 1, and 9999 appears one frame later.
- blank_lz=1, din=16'h0070, dp_in=0 → an pulses only 0001 and 0010 (bcd 0 and 7); the slots for digits 2 and 3 stay dark; frame length is still 20.
- en dropped during the digit 2 slot → an=0 on the next cycle. Re-enable → scan restarts at digit 0 one cycle later with full slot length.
- Assert rst mid-SHOW asynchronously (not on an edge) → an=0, bcd=0 immediately, pending=0. After release with en=1, digit 0 shows 0.
